// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state codes and default sizing.
package uart_pkg;

  localparam int N_REQ_DEFAULT = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_XFER  = 3'd1;
  localparam state_t ST_START = 3'd2;
  localparam state_t ST_BUSY  = 3'd3;
  localparam state_t ST_DRAIN = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first asserted request at or after ptr wins,
// wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  // Scan slots in priority order; once a winner is found later slots are masked.
  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx      = (int'(ptr) + k) % N;
      gnt[idx] = req[idx] & ~found;
      found    = found | req[idx];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte-stream requesters; a grant is held
// for a whole packet and released on the last byte or on an inter-byte timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEFAULT,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic [N_REQ-1:0]   timeout_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYC);

  state_t           state_q,       state_d;
  logic [N_REQ-1:0] grant_q,       grant_d;
  logic [PW-1:0]    rr_ptr_q,      rr_ptr_d;
  logic [7:0]       tx_data_q,     tx_data_d;
  logic             last_q,        last_d;
  logic [CW-1:0]    cnt_q,         cnt_d;
  logic             tx_start_q,    tx_start_d;
  logic [N_REQ-1:0] timeout_err_q, timeout_err_d;

  logic [N_REQ-1:0] arb_gnt_s;
  logic [PW-1:0]    g_idx_s;
  logic [PW-1:0]    rr_next_s;
  logic [7:0]       g_data_s;
  logic             g_valid_s;
  logic             g_last_s;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt_s)
  );

  // Owner's index, byte and qualifiers selected through the one-hot grant.
  always_comb begin
    g_idx_s  = '0;
    g_data_s = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      g_idx_s  = g_idx_s | ({PW{grant_q[i]}} & PW'(i));
      g_data_s = g_data_s | (req_data[8*i +: 8] & {8{grant_q[i]}});
    end
    g_valid_s = |(req_valid & grant_q);
    g_last_s  = |(req_last & grant_q);
    rr_next_s = (g_idx_s == PW'(N_REQ - 1)) ? '0 : g_idx_s + PW'(1);
  end

  // Only the owner may be ready, and only while the transmitter can take a byte.
  always_comb begin
    if (state_q == ST_XFER) begin
      req_ready = grant_q & {N_REQ{~tx_busy}};
    end else begin
      req_ready = '0;
    end
  end

  // Arbitration and transfer sequencing.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    tx_data_d     = tx_data_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    tx_start_d    = 1'b0;
    timeout_err_d = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (|req_valid) begin
          grant_d = arb_gnt_s;
          state_d = ST_XFER;
        end else begin
          grant_d = '0;
        end
      end
      ST_XFER: begin
        if (g_valid_s) begin
          if (!tx_busy) begin
            tx_data_d  = g_data_s;
            last_d     = g_last_s;
            cnt_d      = '0;
            tx_start_d = 1'b1;
            state_d    = ST_START;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          // Saturate rather than wrap so a stalled owner can never escape the limit.
          cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
          if (cnt_d >= TO_LIM) begin
            timeout_err_d = grant_q;
            state_d       = ST_DRAIN;
          end else begin
            state_d = ST_XFER;
          end
        end
      end
      ST_START: begin
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (!tx_busy) begin
          if (last_q) begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            rr_ptr_d = rr_next_s;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DRAIN: begin
        if (!tx_busy) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = rr_next_s;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      tx_data_q     <= 8'h00;
      last_q        <= 1'b0;
      cnt_q         <= '0;
      tx_start_q    <= 1'b0;
      timeout_err_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      tx_data_q     <= tx_data_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      tx_start_q    <= tx_start_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packets are queued per requester, a packet-level
// round-robin model predicts the transmitted byte stream, and a simple transmitter
// model drives tx_busy.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ready, grant, timeout_err;
  logic [8*N-1:0] req_data;
  logic [7:0]     tx_data;
  logic           tx_start, tx_busy;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] q_data  [N][$];
  logic       q_last  [N][$];
  int         m_len   [N][$];
  logic [7:0] m_bytes [N][$];
  logic [7:0] exp_data[$];
  logic [N-1:0] exp_grant[$];

  int   model_ptr  = 0;
  int   busy_len   = 3;
  int   busy_cnt   = 0;
  logic start_prev = 1'b0;
  logic [7:0] held = 8'h00;
  logic hold_valid = 1'b0;
  int   cyc = 0;
  int   t_fall = -1;
  int   n_starts = 0;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit queues_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (q_data[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // One clock: present head-of-queue bytes, retire accepted ones, model the transmitter, check.
  task automatic tick();
    logic [N-1:0] hs;
    for (int i = 0; i < N; i++) begin
      if (q_data[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = q_data[i][0];
        req_last[i] = q_last[i][0];
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
    #1;
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        void'(q_data[i].pop_front());
        void'(q_last[i].pop_front());
      end
    end
    if (start_prev) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    if (tx_busy && busy_cnt == 0) t_fall = cyc;
    tx_busy = (busy_cnt != 0);
    start_prev = tx_start;
    #1;
    chk("ready_not_owner", 32'(req_ready & ~grant), 32'd0);
    chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    if (tx_busy) chk("ready_while_busy", 32'(req_ready), 32'd0);
    if (tx_start) begin
      n_starts++;
      held = tx_data;
      hold_valid = 1'b1;
      if (exp_data.size() > 0) begin
        chk("tx_data", 32'(tx_data), 32'(exp_data.pop_front()));
        chk("tx_grant", 32'(grant), 32'(exp_grant.pop_front()));
      end else begin
        chk("unexpected_start", 32'(tx_start), 32'd0);
      end
    end else if (tx_busy && hold_valid) begin
      chk("tx_data_hold", 32'(tx_data), 32'(held));
    end
  endtask

  task automatic add_pkt(input int i, input int len, input logic [23:0] bytes);
    m_len[i].push_back(len);
    for (int b = 0; b < len; b++) begin
      q_data[i].push_back(bytes[8*b +: 8]);
      q_last[i].push_back(b == len - 1);
      m_bytes[i].push_back(bytes[8*b +: 8]);
    end
  endtask

  // Packet-level model: whole packets in rotating order, pointer moves past each winner.
  task automatic model_commit();
    int pend;
    int w;
    int c;
    int len;
    logic [N-1:0] oh;
    pend = 0;
    for (int i = 0; i < N; i++) pend += m_len[i].size();
    while (pend > 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        c = (model_ptr + k) % N;
        if (w < 0 && m_len[c].size() > 0) w = c;
      end
      len = m_len[w].pop_front();
      oh = '0;
      oh[w] = 1'b1;
      for (int b = 0; b < len; b++) begin
        exp_data.push_back(m_bytes[w].pop_front());
        exp_grant.push_back(oh);
      end
      model_ptr = (w + 1) % N;
      pend--;
    end
  endtask

  task automatic run_drain(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      tick();
      done = (exp_data.size() == 0) && queues_empty() && (grant == '0) && !tx_busy;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"},   32'(grant),       32'd0);
    chk({tag, "_start"},   32'(tx_start),    32'd0);
    chk({tag, "_data"},    32'(tx_data),     32'd0);
    chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
    chk({tag, "_ready"},   32'(req_ready),   32'd0);
  endtask

  initial begin
    logic [3:0] mask;
    int npk;
    int n_to;
    int t_to;
    int s0;
    logic [N-1:0] to_val;

    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    tx_busy = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // All four requesters at once from reset, one byte each.
    busy_len = 4;
    for (int i = 0; i < N; i++) add_pkt(i, 1, 24'($urandom));
    model_commit();
    run_drain("drain_all4_from_reset", 400);

    // Three-byte packet from 0 while 2 waits.
    busy_len = 3;
    add_pkt(0, 3, 24'($urandom));
    add_pkt(2, 1, 24'($urandom));
    model_commit();
    run_drain("drain_no_interleave", 400);

    // Requester 1 alone with a slow transmitter; pointer should land on 2.
    busy_len = 20;
    add_pkt(1, 2, 24'h00AA55);
    model_commit();
    run_drain("drain_single_req1", 400);
    busy_len = 3;
    for (int i = 0; i < N; i++) add_pkt(i, 1, 24'($urandom));
    model_commit();
    run_drain("drain_all4_after_req1", 400);

    // Randomized mixes of requesters, packet counts, lengths and transmitter speed.
    for (int r = 0; r < 10; r++) begin
      mask = 4'($urandom_range(1, 15));
      busy_len = int'($urandom_range(1, 6));
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          npk = int'($urandom_range(1, 2));
          for (int p = 0; p < npk; p++) add_pkt(i, int'($urandom_range(1, 3)), 24'($urandom));
        end
      end
      model_commit();
      run_drain("drain_random", 2000);
    end

    // Requester 3 sends one non-last byte and goes quiet.
    busy_len = 5;
    q_data[3].push_back(8'h3C);
    q_last[3].push_back(1'b0);
    exp_data.push_back(8'h3C);
    exp_grant.push_back(4'b1000);
    n_to = 0;
    t_to = -1;
    to_val = '0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (timeout_err != '0) begin
        n_to++;
        to_val = timeout_err;
        t_to = cyc;
      end
    end
    chk("timeout_pulse_count", 32'(n_to), 32'd1);
    chk("timeout_vector", 32'(to_val), 32'b1000);
    chk("timeout_latency", 32'(t_to - t_fall), 32'(TO + 1));
    chk("timeout_released", 32'(grant), 32'd0);
    chk("timeout_byte_sent", 32'(exp_data.size()), 32'd0);
    model_ptr = (3 + 1) % N;
    busy_len = 2;
    for (int i = 0; i < N; i++) add_pkt(i, 1, 24'($urandom));
    model_commit();
    run_drain("drain_after_timeout", 400);

    // Reset while the transmitter is busy with the first byte of a packet.
    busy_len = 10;
    add_pkt(0, 2, 24'($urandom));
    model_commit();
    s0 = n_starts;
    for (int k = 0; k < 50 && n_starts == s0; k++) tick();
    chk("rst_case_first_start", 32'(n_starts - s0), 32'd1);
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      q_data[i].delete();
      q_last[i].delete();
    end
    exp_data.delete();
    exp_grant.delete();
    hold_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk_reset_outputs("rst_in_busy");
    rst = 1'b0;
    model_ptr = 0;
    s0 = n_starts;
    repeat (30) tick();
    chk("no_start_after_rst", 32'(n_starts - s0), 32'd0);
    for (int i = 0; i < N; i++) add_pkt(i, 1, 24'($urandom));
    model_commit();
    run_drain("drain_after_rst", 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of byte-stream requesters sharing one UART transmitter.
REQ-002 Parameter TIMEOUT_CYC, default 65535: idle cycles allowed to a granted requester between bytes before forced release.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  N_REQ  per-requester byte valid.
REQ-006 req_data  input  8*N_REQ  per-requester byte; requester i on bits [8i+7:8i].
REQ-007 req_last  input  N_REQ  marks final byte of requester's packet; qualified by req_valid.
REQ-008 req_ready  output  N_REQ  byte accepted when req_valid[i] & req_ready[i].
REQ-009 grant  output  N_REQ  one-hot owner of the transmitter; all-zero when idle.
REQ-010 tx_data  output  8  byte to transmitter, held stable from tx_start until tx_busy falls.
REQ-011 tx_start  output  1  one-cycle start pulse to transmitter.
REQ-012 tx_busy  input  1  transmitter busy; rises the cycle after tx_start, falls after stop bit.
REQ-013 timeout_err  output  N_REQ  one-cycle pulse on the timed-out requester's bit.

Function
REQ-014 States: IDLE, XFER, START, BUSY, DRAIN.
REQ-015 IDLE: if any req_valid, grant registered next cycle to first valid requester at or after rr_ptr (wrapping N_REQ-1 -> 0); go XFER. No valid: stay, grant=0.
REQ-016 XFER: req_ready[g] = grant[g] & ~tx_busy, combinational; all other req_ready bits 0 in every state.
REQ-017 XFER transfer: latch req_data[g] into tx_data, latch req_last[g] into last_q, clear timeout counter, go START.
REQ-018 START: tx_start=1 for exactly one cycle; go BUSY.
REQ-019 BUSY: wait for tx_busy==0; then go IDLE if last_q, else XFER.
REQ-020 On exit to IDLE after last byte: rr_ptr <= (g+1) mod N_REQ; grant <= 0 same edge.
REQ-021 Grant is held for the whole packet; req_valid deasserting mid-packet does not release grant.
REQ-022 XFER with req_valid[g]==0: timeout counter increments; on reaching TIMEOUT_CYC, pulse timeout_err[g], go DRAIN.
REQ-023 DRAIN: wait tx_busy==0, then IDLE with rr_ptr <= (g+1) mod N_REQ, grant <= 0.
REQ-024 Timeout counter is ceil(log2(TIMEOUT_CYC+1)) bits, saturating, never wraps.
REQ-025 Minimum IDLE-to-tx_start latency: 3 cycles (grant, transfer, start).
REQ-026 Simultaneous requests: only rotating priority decides; a requester granted last has lowest priority next.
REQ-027 tx_busy high on entry to XFER: req_ready held 0 until it falls; no byte is lost.

Reset
REQ-028 rst on any edge, any state: state=IDLE, grant=0, req_ready=0, tx_start=0, tx_data=8'h00, timeout_err=0, rr_ptr=0, last_q=0, counter=0.
REQ-029 Reset mid-packet abandons the packet with no tx_start issued after reset.

Structure
REQ-030 State enum and default N_REQ live in the shared package uart_pkg.
REQ-031 Round-robin selection is sub-module rr_arbiter (req vector and pointer in, one-hot grant out, combinational).

Verification
REQ-032 Single requester 1 sends 0x55,0xAA(last), tx_busy modelled 20 cycles -> tx_data 0x55 then 0xAA, two tx_start pulses, grant 4'b0010 throughout, rr_ptr=2 after.
REQ-033 All four valid simultaneously from reset, 1-byte packets -> grant order 0,1,2,3; tx_data equals each requester's byte in that order.
REQ-034 Requester 0 sends 3-byte packet while requester 2 valid -> requester 2 granted only after 0's last byte completes; no interleaving.
REQ-035 TIMEOUT_CYC=8, requester 3 sends one non-last byte then drops valid -> timeout_err=4'b1000 for one cycle, grant released after tx_busy falls, rr_ptr=0.
REQ-036 rst asserted in BUSY state -> next cycle all outputs at reset values; no further tx_start until new request.
